// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the eight-bit CPU sequencer: datapath widths,
//   ALU/instruction opcodes, FSM state encoding and small opcode-class helpers.
//   No ports; imported by cpu_ctrl and cpu_regfile.

package cpu_ctrl_pkg;

   localparam int DATA_W  = 8;
   localparam int INSTR_W = 16;
   localparam int OP_W    = 4;
   localparam int REG_AW  = 2;

   localparam logic [OP_W-1:0] OP_AND   = 4'h0;
   localparam logic [OP_W-1:0] OP_OR    = 4'h1;
   localparam logic [OP_W-1:0] OP_ADD   = 4'h2;
   localparam logic [OP_W-1:0] OP_SUB   = 4'h3;
   localparam logic [OP_W-1:0] OP_INC   = 4'h4;
   localparam logic [OP_W-1:0] OP_DEC   = 4'h5;
   localparam logic [OP_W-1:0] OP_COMP  = 4'h6;
   localparam logic [OP_W-1:0] OP_CHECK = 4'h7;
   localparam logic [OP_W-1:0] OP_LOAD  = 4'h8;
   localparam logic [OP_W-1:0] OP_STORE = 4'h9;
   localparam logic [OP_W-1:0] OP_LI    = 4'hA;
   localparam logic [OP_W-1:0] OP_JMP   = 4'hB;
   localparam logic [OP_W-1:0] OP_JNZ   = 4'hC;
   localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

   // Value presented on alu_op whenever the sequencer is not in EXEC.
   localparam logic [OP_W-1:0] ALU_IDLE = OP_AND;

   localparam logic [DATA_W-1:0] PC_STEP = 8'h01;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   // Ops whose result lands in R[rd] during WB (straight from res).
   function automatic logic is_alu_wb(input logic [OP_W-1:0] op);
      return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC) ||
             (op == OP_LI);
   endfunction

   // Ops that substitute the immediate for operand A.
   function automatic logic uses_imm(input logic [OP_W-1:0] op);
      return (op == OP_LI) || (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic sets_flag(input logic [OP_W-1:0] op);
      return (op == OP_COMP) || (op == OP_CHECK);
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile
//   NREG x DW register file: two combinational read ports, one synchronous
//   write port gated by we. Synchronous active-high reset clears every entry.
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   ra, rb         in   read addresses
//   rdata_a/b      out  read data (combinational)
//   we, wa, wd     in   write enable / address / data

module cpu_regfile
   import cpu_ctrl_pkg::*;
#(
   parameter int NREG = 4,
   parameter int DW   = DATA_W,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ra,
   input  logic [AW-1:0] rb,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd
);

   logic [DW-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign rdata_a = regs[ra];
   assign rdata_b = regs[rb];

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl
//   Multi-cycle fetch/decode/execute sequencer for the eight-bit CPU. Holds
//   pc, ir, res, flag and the register file; drives the alu and the
//   instruction/data memories.
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   imem_addr/imem_data instruction ROM, data valid one cycle after address
//   dmem_addr/wdata/we  data RAM address, store data, one-cycle store strobe
//   dmem_rdata          RAM load data, valid one cycle after address
//   alu_op/ina/inb      alu request (zero outside EXEC)
//   alu_out/alu_zf      alu result and zero flag (combinational)
//   halted              set once HALT executes
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | imem_addr = pc; ROM captures the word at the edge
// S_DECODE | ir <= imem_data
// S_EXEC   | drive alu, latch res (and flag for COMP/CHECK), update pc
// S_MEM    | dmem_addr = res; STORE pulses dmem_we, LOAD starts the read
// S_WB     | R[rd] <= res or dmem_rdata
// S_HALT   | absorbing; only rst leaves

module cpu_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter logic [DATA_W-1:0] PC_RESET = 8'h00,
   parameter int                NREG     = 4
) (
   input  logic               clk,
   input  logic               rst,
   output logic [DATA_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [DATA_W-1:0]  dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   output logic               dmem_we,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic [OP_W-1:0]    alu_op,
   output logic [DATA_W-1:0]  alu_ina,
   output logic [DATA_W-1:0]  alu_inb,
   input  logic [DATA_W-1:0]  alu_out,
   input  logic               alu_zf,
   output logic               halted
);

   state_t               state;
   state_t               state_nxt;
   logic [DATA_W-1:0]    pc;
   logic [DATA_W-1:0]    pc_nxt;
   logic [INSTR_W-1:0]   ir;
   logic [DATA_W-1:0]    res;
   logic                 flag;

   logic [OP_W-1:0]      op;
   logic [REG_AW-1:0]    rd;
   logic [REG_AW-1:0]    rs;
   logic [DATA_W-1:0]    imm;

   logic [DATA_W-1:0]    rdata_a;
   logic [DATA_W-1:0]    rdata_b;
   logic                 rf_we;
   logic [DATA_W-1:0]    rf_wd;

   assign op  = ir[15:12];
   assign rd  = ir[11:10];
   assign rs  = ir[9:8];
   assign imm = ir[7:0];

   cpu_regfile #(
      .NREG (NREG),
      .DW   (DATA_W),
      .AW   (REG_AW)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra      (rd),
      .rb      (rs),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b),
      .we      (rf_we),
      .wa      (rd),
      .wd      (rf_wd)
   );

   assign imem_addr  = pc;
   assign dmem_addr  = res;
   assign dmem_wdata = rdata_a;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_FETCH;
         pc     <= PC_RESET;
         ir     <= '0;
         res    <= '0;
         flag   <= 1'b0;
         halted <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (state == S_DECODE) begin
            ir <= imem_data;
         end
         if (state == S_EXEC) begin
            res <= alu_out;
            if (sets_flag(op)) begin
               flag <= alu_zf;
            end
            if (op == OP_HALT) begin
               halted <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      alu_op    = ALU_IDLE;
      alu_ina   = '0;
      alu_inb   = '0;
      rf_we     = 1'b0;
      rf_wd     = res;
      dmem_we   = 1'b0;

      unique case (state)
         S_FETCH: begin
            state_nxt = S_DECODE;
         end

         S_DECODE: begin
            state_nxt = S_EXEC;
         end

         S_EXEC: begin
            alu_op  = op;
            alu_ina = uses_imm(op) ? imm : rdata_a;
            alu_inb = rdata_b;
            pc_nxt  = pc + PC_STEP;
            if (is_alu_wb(op)) begin
               state_nxt = S_WB;
            end else if ((op == OP_LOAD) || (op == OP_STORE)) begin
               state_nxt = S_MEM;
            end else if (op == OP_HALT) begin
               state_nxt = S_HALT;
               pc_nxt    = pc;
            end else begin
               // COMP, CHECK, JMP, JNZ and undefined opcodes retire here.
               state_nxt = S_FETCH;
               if (op == OP_JMP) begin
                  pc_nxt = imm;
               end else if ((op == OP_JNZ) && !flag) begin
                  pc_nxt = imm;
               end
            end
         end

         S_MEM: begin
            // Gated by rst so a store interrupted by reset never reaches RAM.
            dmem_we   = (op == OP_STORE) && !rst;
            state_nxt = (op == OP_LOAD) ? S_WB : S_FETCH;
         end

         S_WB: begin
            rf_we     = 1'b1;
            rf_wd     = (op == OP_LOAD) ? dmem_rdata : res;
            state_nxt = S_FETCH;
         end

         S_HALT: begin
            state_nxt = S_HALT;
         end

         default: begin
            state_nxt = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl
//   Directed bench for cpu_ctrl with a behavioural alu, synchronous ROM and
//   synchronous RAM. Expected register values and store events are pushed
//   to scoreboard queues as each program is set up and popped when the DUT
//   reaches the corresponding checkpoint or raises dmem_we.

module tb_cpu_ctrl;

   localparam logic [3:0] T_AND = 4'h0, T_OR = 4'h1, T_ADD = 4'h2, T_SUB = 4'h3,
                          T_INC = 4'h4, T_DEC = 4'h5, T_COMP = 4'h6, T_CHECK = 4'h7,
                          T_LOAD = 4'h8, T_STORE = 4'h9, T_LI = 4'hA, T_JMP = 4'hB,
                          T_JNZ = 4'hC, T_HALT = 4'hF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [7:0]  dmem_addr;
   logic [7:0]  dmem_wdata;
   logic        dmem_we;
   logic [7:0]  dmem_rdata;
   logic [3:0]  alu_op;
   logic [7:0]  alu_ina;
   logic [7:0]  alu_inb;
   logic [7:0]  alu_out;
   logic        alu_zf;
   logic        halted;

   logic [15:0] rom [256];
   logic [7:0]  ram [256];

   int n_assert = 0;
   int n_fail   = 0;
   int n_pulse  = 0;

   logic [7:0]  exp_reg [$];
   logic [15:0] exp_store [$];

   always #5 clk = ~clk;

   cpu_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_we    (dmem_we),
      .dmem_rdata (dmem_rdata),
      .alu_op     (alu_op),
      .alu_ina    (alu_ina),
      .alu_inb    (alu_inb),
      .alu_out    (alu_out),
      .alu_zf     (alu_zf),
      .halted     (halted)
   );

   always @(posedge clk) begin
      imem_data <= rom[imem_addr];
      if (dmem_we) ram[dmem_addr] <= dmem_wdata;
      dmem_rdata <= ram[dmem_addr];
   end

   always_comb begin
      alu_out = 8'h00;
      case (alu_op)
         T_AND:   alu_out = alu_ina & alu_inb;
         T_OR:    alu_out = alu_ina | alu_inb;
         T_ADD:   alu_out = alu_ina + alu_inb;
         T_SUB:   alu_out = alu_ina - alu_inb;
         T_INC:   alu_out = alu_ina + 8'd1;
         T_DEC:   alu_out = alu_ina - 8'd1;
         T_COMP:  alu_out = alu_ina - alu_inb;
         T_CHECK: alu_out = alu_ina;
         T_LOAD, T_STORE, T_LI: alu_out = alu_ina;
         default: alu_out = 8'h00;
      endcase
      alu_zf = (alu_out == 8'h00);
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Store monitor: every dmem_we pulse must match the next queued store.
   always @(negedge clk) begin
      if (dmem_we) begin
         n_pulse++;
         if (exp_store.size() == 0) begin
            chk("unexpected_store", {dmem_addr, dmem_wdata}, 16'hxxxx);
         end else begin
            chk("store_addr_data", {dmem_addr, dmem_wdata}, exp_store.pop_front());
         end
      end
   end

   function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         rom[i] = 16'h0000;
         ram[i] = 8'h00;
      end
   endtask

   task automatic expect_regs(input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] r3);
      exp_reg.push_back(r0);
      exp_reg.push_back(r1);
      exp_reg.push_back(r2);
      exp_reg.push_back(r3);
   endtask

   task automatic check_regs(input string tag);
      logic [7:0] obs [4];
      obs[0] = dut.u_regfile.regs[0];
      obs[1] = dut.u_regfile.regs[1];
      obs[2] = dut.u_regfile.regs[2];
      obs[3] = dut.u_regfile.regs[3];
      for (int i = 0; i < 4; i++) begin
         if (exp_reg.size() == 0) begin
            chk({tag, "_queue_empty"}, {8'h00, obs[i]}, 16'hxxxx);
         end else begin
            chk($sformatf("%s_r%0d", tag, i), {8'h00, obs[i]}, {8'h00, exp_reg.pop_front()});
         end
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_rst_pc"}, {8'h00, imem_addr}, 16'h0000);
      chk({tag, "_rst_halted"}, {15'h0, halted}, 16'h0000);
      chk({tag, "_rst_alu"}, {alu_op, alu_ina, alu_inb[3:0]}, 16'h0000);
      chk({tag, "_rst_we"}, {15'h0, dmem_we}, 16'h0000);
      rst = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bit got;

      // 1: LI r0,5; LI r1,3; ADD r0,r1 -> r0=8 after 12 cycles
      clear_mem();
      rom[0] = ins(T_LI, 2'd0, 2'd0, 8'd5);
      rom[1] = ins(T_LI, 2'd1, 2'd0, 8'd3);
      rom[2] = ins(T_ADD, 2'd0, 2'd1, 8'd0);
      expect_regs(8'h00, 8'h00, 8'h00, 8'h00);
      do_reset("t1");
      check_regs("t1_reset");
      expect_regs(8'd8, 8'd3, 8'h00, 8'h00);
      step(12);
      check_regs("t1_add");
      chk("t1_flag", {15'h0, dut.flag}, 16'h0000);
      chk("t1_pc", {8'h00, imem_addr}, 16'h0003);

      // 2a: equal compare -> flag=1, JNZ not taken
      clear_mem();
      rom[0] = ins(T_LI, 2'd0, 2'd0, 8'd7);
      rom[1] = ins(T_LI, 2'd1, 2'd0, 8'd7);
      rom[2] = ins(T_COMP, 2'd0, 2'd1, 8'd0);
      rom[3] = ins(T_JNZ, 2'd0, 2'd0, 8'h20);
      do_reset("t2a");
      expect_regs(8'd7, 8'd7, 8'h00, 8'h00);
      step(14);
      chk("t2a_flag", {15'h0, dut.flag}, 16'h0001);
      chk("t2a_pc", {8'h00, imem_addr}, 16'h0004);
      check_regs("t2a");

      // 2b: unequal compare -> flag=0, JNZ taken
      rom[1] = ins(T_LI, 2'd1, 2'd0, 8'd6);
      do_reset("t2b");
      expect_regs(8'd7, 8'd6, 8'h00, 8'h00);
      step(14);
      chk("t2b_flag", {15'h0, dut.flag}, 16'h0000);
      chk("t2b_pc", {8'h00, imem_addr}, 16'h0020);
      check_regs("t2b");

      // 3: store then load through RAM
      clear_mem();
      rom[0] = ins(T_LI, 2'd2, 2'd0, 8'hAA);
      rom[1] = ins(T_STORE, 2'd2, 2'd0, 8'h10);
      rom[2] = ins(T_LOAD, 2'd3, 2'd0, 8'h10);
      do_reset("t3");
      exp_store.push_back({8'h10, 8'hAA});
      expect_regs(8'h00, 8'h00, 8'hAA, 8'hAA);
      step(13);
      check_regs("t3");
      chk("t3_ram", {8'h00, ram[8'h10]}, 16'h00AA);
      chk("t3_pulses", n_pulse[15:0], 16'd1);
      chk("t3_store_q", exp_store.size(), 16'd0);

      // 4: INC at pc=FF wraps both data and pc; flag untouched by INC
      clear_mem();
      rom[0]     = ins(T_LI, 2'd0, 2'd0, 8'hFF);
      rom[1]     = ins(T_JMP, 2'd0, 2'd0, 8'hFF);
      rom[8'hFF] = ins(T_INC, 2'd0, 2'd0, 8'h00);
      do_reset("t4");
      step(7);
      chk("t4_pc_ff", {8'h00, imem_addr}, 16'h00FF);
      expect_regs(8'h00, 8'h00, 8'h00, 8'h00);
      step(4);
      check_regs("t4");
      chk("t4_pc_wrap", {8'h00, imem_addr}, 16'h0000);
      chk("t4_flag", {15'h0, dut.flag}, 16'h0000);

      // 5: reset during MEM of a STORE discards the store
      clear_mem();
      ram[8'h20] = 8'h33;
      rom[0] = ins(T_LI, 2'd1, 2'd0, 8'h55);
      rom[1] = ins(T_STORE, 2'd1, 2'd0, 8'h20);
      do_reset("t5");
      step(7);
      chk("t5_mem_addr", {8'h00, dmem_addr}, 16'h0020);
      rst = 1'b1;
      #1;
      chk("t5_we_in_rst", {15'h0, dmem_we}, 16'h0000);
      expect_regs(8'h00, 8'h00, 8'h00, 8'h00);
      step(1);
      check_regs("t5");
      chk("t5_pc", {8'h00, imem_addr}, 16'h0000);
      chk("t5_ram", {8'h00, ram[8'h20]}, 16'h0033);

      // 6: undefined opcode then HALT; everything frozen afterwards
      clear_mem();
      rom[0] = ins(T_LI, 2'd1, 2'd0, 8'd9);
      rom[1] = 16'hD5C3;
      rom[2] = ins(T_HALT, 2'd0, 2'd0, 8'h00);
      do_reset("t6");
      step(7);
      chk("t6_pc_after_nop", {8'h00, imem_addr}, 16'h0002);
      got = 1'b0;
      for (int i = 0; i < 3 && !got; i++) begin
         step(1);
         if (halted) got = 1'b1;
      end
      chk("t6_halted_in_3", {15'h0, got}, 16'h0001);
      expect_regs(8'h00, 8'd9, 8'h00, 8'h00);
      step(20);
      chk("t6_halted_hold", {15'h0, halted}, 16'h0001);
      chk("t6_pc_frozen", {8'h00, imem_addr}, 16'h0002);
      check_regs("t6");

      do_reset("final");
      chk("final_pulses", n_pulse[15:0], 16'd1);
      chk("final_reg_q", exp_reg.size(), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
